cache_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data cache between two requesters (port 0: instruction fetch, port 1: load/store unit). It grants one requester at a time, drives the cache's data/address/write inputs, waits for the cache response, and returns read data and miss status to the granted requester. It sits directly between the core's memory ports and the `cache` instance.

---
 rtl/cache_arbiter_if.sv | 43 ++++
 rtl/cache_arbiter.sv | 116 +++++++++++
 tb/tb_cache_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_if.sv
// Core request ports and cache bus around cache_arbiter.
// slave = arbiter view, master = core/cache side.
interface cache_arbiter_if;
  logic        m0_req;
  logic        m1_req;
  logic        m0_wr;
  logic        m1_wr;
  logic [31:0] m0_addr;
  logic [31:0] m1_addr;
  logic [31:0] m0_data;
  logic [31:0] m1_data;
  logic        m0_done;
  logic        m1_done;
  logic [31:0] m0_out;
  logic [31:0] m1_out;
  logic        m0_miss;
  logic        m1_miss;
  logic        busy;
  logic [31:0] c_data;
  logic [31:0] c_addr;
  logic        c_wr;
  logic        c_response;
  logic        c_is_missrate;
  logic [31:0] c_out;

  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr,
    input  m0_addr, m1_addr, m0_data, m1_data,
    output m0_done, m1_done, m0_out, m1_out,
    output m0_miss, m1_miss, busy,
    output c_data, c_addr, c_wr,
    input  c_response, c_is_missrate, c_out
  );

  modport master (
    output m0_req, m1_req, m0_wr, m1_wr,
    output m0_addr, m1_addr, m0_data, m1_data,
    input  m0_done, m1_done, m0_out, m1_out,
    input  m0_miss, m1_miss, busy,
    input  c_data, c_addr, c_wr,
    output c_response, c_is_missrate, c_out
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-port arbiter in front of the single-port data cache.
// CACHE_ARB_RR_EN selects round-robin, else port 0 fixed priority.
module cache_arbiter #(
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  cache_arbiter_if.slave bus
);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          win_q;
  logic          wr_q;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic          any_req;
  logic          pick;

  assign any_req = bus.m0_req | bus.m1_req;

`ifdef CACHE_ARB_RR_EN
  logic ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else if (state_q == S_DONE) ptr_q <= ~win_q;
  end

  assign pick = (bus.m0_req & bus.m1_req) ? ptr_q : ~bus.m0_req;
`else
  assign pick = ~bus.m0_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (any_req) state_d = S_ISSUE;
      S_ISSUE:  state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == '0) state_d = S_WAIT;
      S_WAIT:   if (bus.c_response) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      win_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      bus.c_wr    <= 1'b0;
      bus.c_addr  <= '0;
      bus.c_data  <= '0;
      bus.m0_done <= 1'b0;
      bus.m1_done <= 1'b0;
      bus.m0_out  <= '0;
      bus.m1_out  <= '0;
      bus.m0_miss <= 1'b0;
      bus.m1_miss <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      bus.m0_done <= 1'b0;
      bus.m1_done <= 1'b0;
      bus.busy    <= (state_d != S_IDLE);
      unique case (state_q)
        S_IDLE: begin
          if (any_req) begin
            win_q  <= pick;
            wr_q   <= pick ? bus.m1_wr   : bus.m0_wr;
            addr_q <= pick ? bus.m1_addr : bus.m0_addr;
            data_q <= pick ? bus.m1_data : bus.m0_data;
          end
        end
        S_ISSUE: begin
          bus.c_wr   <= wr_q;
          bus.c_addr <= addr_q;
          bus.c_data <= data_q;
          cnt_q      <= CW'(SETTLE - 1);
        end
        S_SETTLE: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        S_WAIT: begin
          // writes never report a miss, whatever the cache flag says
          if (bus.c_response) begin
            if (win_q) begin
              bus.m1_out  <= bus.c_out;
              bus.m1_miss <= ~wr_q & bus.c_is_missrate;
            end else begin
              bus.m0_out  <= bus.c_out;
              bus.m0_miss <= ~wr_q & bus.c_is_missrate;
            end
          end
        end
        S_DONE: begin
          bus.m0_done <= ~win_q;
          bus.m1_done <= win_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter with a small behavioural cache model.
// Vector table plus hand sequences for reset abort and arbitration.
module tb_cache_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cache_arbiter_if bus();

  cache_arbiter #(.SETTLE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          port;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_out;
    bit          exp_miss;
    int          exp_n;
    bit          same;
  } vec_t;

  typedef struct {
    bit          port;
    logic [31:0] out;
    bit          miss;
  } exp_t;

  int   cmp  = 0;
  int   errs = 0;
  exp_t sb[$];
  bit   gl[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // cache model: hit = 1 cycle, miss = 4 cycles; unchanged inputs keep response
  logic [31:0] mdat [0:15];
  logic [31:0] mtag [0:15];
  logic        mvld [0:15] = '{default: 1'b0};
  logic [64:0] prev = '1;
  int          lat  = 0;
  bit          pmiss;
  logic [3:0]  idx;
  logic        hit;

  assign idx = {bus.c_addr[15:14], bus.c_addr[5:4]};
  assign hit = mvld[idx] && (mtag[idx] == bus.c_addr);

  initial forever begin
    @(negedge clk);
    if ({bus.c_wr, bus.c_addr, bus.c_data} !== prev) begin
      prev = {bus.c_wr, bus.c_addr, bus.c_data};
      bus.c_response = 1'b0;
      lat   = (bus.c_wr || hit) ? 1 : 4;
      pmiss = !bus.c_wr && !hit;
    end else if (lat != 0) begin
      if (lat == 1) begin
        bus.c_response    = 1'b1;
        bus.c_is_missrate = pmiss;
        if (bus.c_wr)  bus.c_out = bus.c_data;
        else if (hit)  bus.c_out = mdat[idx];
        else           bus.c_out = {16'hC0DE, bus.c_addr[15:0]};
        mdat[idx] = bus.c_out;
        mtag[idx] = bus.c_addr;
        mvld[idx] = 1'b1;
      end
      lat--;
    end
  end

  // scoreboard monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus.m0_done && bus.m1_done)
      chk("both_done", 32'd1, 32'd0);
    if (bus.m0_done || bus.m1_done) begin
      gl.push_back(bus.m1_done);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_port", {31'd0, bus.m1_done}, {31'd0, e.port});
        chk("sb_out", e.port ? bus.m1_out : bus.m0_out, e.out);
        chk("sb_miss", {31'd0, e.port ? bus.m1_miss : bus.m0_miss},
            {31'd0, e.miss});
      end
    end
  end

  task automatic run_vec(vec_t v);
    int          n = 0;
    bit          got = 0;
    bit          stable = 1;
    logic [31:0] oth;
    exp_t        e;
    @(negedge clk);
    if (v.port) begin
      bus.m1_wr = v.wr; bus.m1_addr = v.addr;
      bus.m1_data = v.data; bus.m1_req = 1'b1;
    end else begin
      bus.m0_wr = v.wr; bus.m0_addr = v.addr;
      bus.m0_data = v.data; bus.m0_req = 1'b1;
    end
    e.port = v.port; e.out = v.exp_out; e.miss = v.exp_miss;
    sb.push_back(e);
    oth = v.port ? bus.m0_out : bus.m1_out;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = v.port ? bus.m1_done : bus.m0_done;
      if (!got && n >= (v.same ? 1 : 2) && bus.c_addr !== v.addr)
        stable = 0;
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    if (!got) void'(sb.pop_back());
    chk("latency", n, v.exp_n);
    chk("c_stable", {31'd0, stable}, 32'd1);
    chk("other_out", v.port ? bus.m0_out : bus.m1_out, oth);
    @(negedge clk);
    chk("done_pulse", {31'd0, bus.m0_done | bus.m1_done}, 32'd0);
  endtask

  vec_t vt[8];
  vec_t vx;
  bit   okd;
  int   t;

  initial begin
    bus.m0_req = 0; bus.m0_wr = 0; bus.m0_addr = '0; bus.m0_data = '0;
    bus.m1_req = 0; bus.m1_wr = 0; bus.m1_addr = '0; bus.m1_data = '0;
    vt[0] = '{0, 1, 32'h10,   32'hDEADBEEF, 32'hDEADBEEF, 0, 5, 0};
    vt[1] = '{1, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 5, 0};
    vt[2] = '{1, 0, 32'h4010, 32'h0,        32'hC0DE4010, 1, 8, 0};
    vt[3] = '{0, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 5, 0};
    vt[4] = '{0, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 5, 1};
    vt[5] = '{1, 1, 32'h20,   32'h12345678, 32'h12345678, 0, 5, 0};
    vt[6] = '{0, 0, 32'h20,   32'h0,        32'h12345678, 0, 5, 0};
    vt[7] = '{0, 0, 32'h30,   32'h0,        32'hC0DE0030, 1, 8, 0};

    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_c_addr", bus.c_addr, 32'd0);
    chk("rst_c_data", bus.c_data, 32'd0);
    chk("rst_c_wr", {31'd0, bus.c_wr}, 32'd0);
    chk("rst_done", {30'd0, bus.m1_done, bus.m0_done}, 32'd0);
    chk("rst_m0_out", bus.m0_out, 32'd0);
    chk("rst_m1_out", bus.m1_out, 32'd0);
    chk("rst_miss", {30'd0, bus.m1_miss, bus.m0_miss}, 32'd0);
    repeat (6) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // reset while a port 1 miss waits on the cache
    @(negedge clk);
    bus.m1_wr = 0; bus.m1_addr = 32'h8010; bus.m1_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("busy_wait", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_c_addr", bus.c_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.m1_req = 1'b0;
    okd = 1;
    repeat (6) begin
      @(negedge clk);
      if (bus.m1_done) okd = 0;
    end
    chk("abort_no_done", {31'd0, okd}, 32'd1);
    vx = '{0, 0, 32'h4010, 32'h0, 32'hC0DE4010, 0, 5, 0};
    run_vec(vx);

    // both ports requesting continuously from a fresh pointer
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    gl.delete();
    bus.m0_wr = 0; bus.m0_addr = 32'h10;
    bus.m1_wr = 0; bus.m1_addr = 32'h20;
    bus.m0_req = 1'b1; bus.m1_req = 1'b1;
    t = 0;
    while (gl.size() < 8 && t < 200) begin
      @(negedge clk);
      t++;
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    chk("arb_count", gl.size(), 8);
    for (int i = 0; i < 8 && i < gl.size(); i++) begin
`ifdef CACHE_ARB_RR_EN
      chk($sformatf("arb_grant%0d", i), {31'd0, gl[i]}, i % 2);
`else
      chk($sformatf("arb_grant%0d", i), {31'd0, gl[i]}, 32'd0);
`endif
    end
    repeat (4) @(negedge clk);
    chk("end_idle", {31'd0, bus.busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
